// File: rtl/ascon_ctrl_pkg.sv
// Shared types and constants for the ASCON job scheduler slice.
package ascon_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KEY   = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } sched_state_e;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_ZERO  = 2'b01;
   localparam logic [1:0] ERR_NOKEY = 2'b10;
   localparam logic [1:0] ERR_TMO   = 2'b11;

   localparam logic MODE_HASH = 1'b0;
   localparam logic MODE_AEAD = 1'b1;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ascon_job_sched_rr_arb2.sv
// Two-way round-robin arbiter; the last winner loses ties.
module rr_arb2
   import ascon_ctrl_pkg::*;
(
   input  logic       sub_clk_i,
   input  logic       sub_rst_i,
   input  logic [1:0] req_vld,
   input  logic       accept,
   output logic       gnt_id,
   output logic       gnt_vld
);

   logic last_grant_r;

   // grant selection from current requests and previous winner
   always_comb begin
      gnt_vld = |req_vld;
      case (req_vld)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ~last_grant_r;
         default: gnt_id = 1'b0;
      endcase
   end

   // remember the winner; reset value hands requester 0 the first tie
   always_ff @(posedge sub_clk_i) begin
      if (sub_rst_i) begin
         last_grant_r <= 1'b1;
      end else if (accept && gnt_vld) begin
         last_grant_r <= gnt_id;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

endmodule

// File: rtl/ascon_job_sched.sv
// Round-robin job scheduler sequencing key load, start pulses and frame counting.
module ascon_job_sched
   import ascon_ctrl_pkg::*;
#(
   parameter int FRAME_W = 8,
   parameter int TMO_W   = 16
)(
   input  logic               sub_clk_i,
   input  logic               sub_rst_i,
   input  logic [1:0]         req_vld_i,
   output logic [1:0]         req_rdy_o,
   input  logic [1:0]         req_mode_i,
   input  logic [1:0]         req_newkey_i,
   input  logic [FRAME_W-1:0] req_frames0_i,
   input  logic [FRAME_W-1:0] req_frames1_i,
   output logic               key_trigger_o,
   output logic               hash_start_o,
   output logic               aead_start_o,
   input  logic               key_done_i,
   input  logic               frame_done_i,
   output logic               busy_o,
   output logic               grant_id_o,
   output logic               done_o,
   output logic               done_id_o,
   output logic               err_o,
   output logic [1:0]         err_code_o
);

   sched_state_e       state_r, state_nxt_s;
   logic [1:0]         code_nxt_s;
   logic               gnt_id_s, gnt_vld_s, accept_s;
   logic               mode_in_s, newkey_in_s, mode_job_s, job_id_s;
   logic [FRAME_W-1:0] frames_in_s;
   logic               mode_r, grant_id_r, key_valid_r;
   logic [FRAME_W-1:0] frames_r, frames_left_r;
   logic [TMO_W-1:0]   wdog_r;
   logic               wdog_max_s, last_frame_s;
   logic               key_trigger_s, hash_start_s, aead_start_s, busy_s;
   logic               done_s, err_s, done_id_s;
   logic [1:0]         err_code_s;

   assign accept_s = (state_r == ST_IDLE);

   rr_arb2 u_arb (
      .sub_clk_i (sub_clk_i),
      .sub_rst_i (sub_rst_i),
      .req_vld   (req_vld_i),
      .accept    (accept_s),
      .gnt_id    (gnt_id_s),
      .gnt_vld   (gnt_vld_s)
   );

   // decode the granted requester's command and job context
   always_comb begin
      mode_in_s    = req_mode_i[gnt_id_s];
      newkey_in_s  = req_newkey_i[gnt_id_s];
      frames_in_s  = gnt_id_s ? req_frames1_i : req_frames0_i;
      mode_job_s   = (state_r == ST_IDLE) ? mode_in_s : mode_r;
      job_id_s     = (state_r == ST_IDLE) ? gnt_id_s : grant_id_r;
      wdog_max_s   = &wdog_r;
      last_frame_s = (frames_left_r == {{(FRAME_W-1){1'b0}}, 1'b1});
      req_rdy_o    = (accept_s && gnt_vld_s) ? onehot2(gnt_id_s) : 2'b00;
   end

   // state register
   always_ff @(posedge sub_clk_i) begin
      if (sub_rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state and error classification
   always_comb begin
      state_nxt_s = state_r;
      code_nxt_s  = ERR_NONE;
      case (state_r)
         ST_IDLE: begin
            if (!gnt_vld_s) begin
               state_nxt_s = ST_IDLE;
            end else if (frames_in_s == {FRAME_W{1'b0}}) begin
               state_nxt_s = ST_ERR;
               code_nxt_s  = ERR_ZERO;
            end else if (newkey_in_s) begin
               state_nxt_s = ST_KEY;
            end else if ((mode_in_s == MODE_AEAD) && !key_valid_r) begin
               state_nxt_s = ST_ERR;
               code_nxt_s  = ERR_NOKEY;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_KEY: begin
            if (key_done_i) begin
               state_nxt_s = ST_START;
            end else if (wdog_max_s) begin
               state_nxt_s = ST_ERR;
               code_nxt_s  = ERR_TMO;
            end else begin
               state_nxt_s = ST_KEY;
            end
         end
         ST_START: state_nxt_s = ST_RUN;
         ST_RUN: begin
            if (frame_done_i) begin
               state_nxt_s = last_frame_s ? ST_DONE : ST_RUN;
            end else if (wdog_max_s) begin
               state_nxt_s = ST_ERR;
               code_nxt_s  = ERR_TMO;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         ST_ERR:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // output values for the coming cycle, derived from the transition
   always_comb begin
      key_trigger_s = (state_r != ST_KEY) && (state_nxt_s == ST_KEY);
      hash_start_s  = (state_nxt_s == ST_START) && (mode_job_s == MODE_HASH);
      aead_start_s  = (state_nxt_s == ST_START) && (mode_job_s == MODE_AEAD);
      busy_s        = (state_nxt_s != ST_IDLE);
      done_s        = (state_nxt_s == ST_DONE);
      err_s         = (state_nxt_s == ST_ERR);
      err_code_s    = err_s ? code_nxt_s : ERR_NONE;
      done_id_s     = (done_s || err_s) ? job_id_s : 1'b0;
   end

   // registered outputs
   always_ff @(posedge sub_clk_i) begin
      if (sub_rst_i) begin
         key_trigger_o <= 1'b0;
         hash_start_o  <= 1'b0;
         aead_start_o  <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
         err_code_o    <= ERR_NONE;
         done_id_o     <= 1'b0;
      end else begin
         key_trigger_o <= key_trigger_s;
         hash_start_o  <= hash_start_s;
         aead_start_o  <= aead_start_s;
         busy_o        <= busy_s;
         done_o        <= done_s;
         err_o         <= err_s;
         err_code_o    <= err_code_s;
         done_id_o     <= done_id_s;
      end
   end

   // job context, frame counter, key validity and watchdog
   always_ff @(posedge sub_clk_i) begin
      if (sub_rst_i) begin
         mode_r        <= MODE_HASH;
         grant_id_r    <= 1'b0;
         frames_r      <= {FRAME_W{1'b0}};
         frames_left_r <= {FRAME_W{1'b0}};
         key_valid_r   <= 1'b0;
         wdog_r        <= {TMO_W{1'b0}};
      end else begin
         if (accept_s && gnt_vld_s) begin
            mode_r     <= mode_in_s;
            grant_id_r <= gnt_id_s;
            frames_r   <= frames_in_s;
         end else begin
            mode_r     <= mode_r;
            grant_id_r <= grant_id_r;
            frames_r   <= frames_r;
         end

         if (state_r == ST_START) begin
            frames_left_r <= frames_r;
         end else if ((state_r == ST_RUN) && frame_done_i) begin
            frames_left_r <= frames_left_r - {{(FRAME_W-1){1'b0}}, 1'b1};
         end else begin
            frames_left_r <= frames_left_r;
         end

         if (key_trigger_s) begin
            key_valid_r <= 1'b0;
         end else if ((state_r == ST_KEY) && key_done_i) begin
            key_valid_r <= 1'b1;
         end else if (err_s && (code_nxt_s == ERR_TMO)) begin
            key_valid_r <= 1'b0;
         end else begin
            key_valid_r <= key_valid_r;
         end

         // progress on either handshake restarts the timeout window
         if ((state_nxt_s != state_r) || key_done_i || frame_done_i) begin
            wdog_r <= {TMO_W{1'b0}};
         end else if ((state_r == ST_KEY) || (state_r == ST_RUN)) begin
            wdog_r <= wdog_r + {{(TMO_W-1){1'b0}}, 1'b1};
         end else begin
            wdog_r <= {TMO_W{1'b0}};
         end
      end
   end

   assign grant_id_o = grant_id_r;

endmodule

// File: tb/tb_ascon_job_sched.sv
// Directed, table-driven bench for the ASCON job scheduler.
module tb_ascon_job_sched;

   localparam int FW = 8;
   localparam int TW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    req_vld = 2'b00, req_mode = 2'b00, req_newkey = 2'b00;
   logic [FW-1:0] fr0 = 8'd0, fr1 = 8'd0;
   logic          key_done = 1'b0, frame_done = 1'b0;
   logic [1:0]    req_rdy, err_code;
   logic          key_trigger, hash_start, aead_start, busy, grant_id;
   logic          done, done_id, err;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   ascon_job_sched #(.FRAME_W(FW), .TMO_W(TW)) dut (
      .sub_clk_i     (clk),
      .sub_rst_i     (rst),
      .req_vld_i     (req_vld),
      .req_rdy_o     (req_rdy),
      .req_mode_i    (req_mode),
      .req_newkey_i  (req_newkey),
      .req_frames0_i (fr0),
      .req_frames1_i (fr1),
      .key_trigger_o (key_trigger),
      .hash_start_o  (hash_start),
      .aead_start_o  (aead_start),
      .key_done_i    (key_done),
      .frame_done_i  (frame_done),
      .busy_o        (busy),
      .grant_id_o    (grant_id),
      .done_o        (done),
      .done_id_o     (done_id),
      .err_o         (err),
      .err_code_o    (err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] vld, mode, nk;
      logic [7:0] f0, f1;
      logic [1:0] rdy;
      logic       kt, hs, as_, er;
      logic [1:0] code;
      logic       id;
      int         nfr;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // present a command, check the same-cycle rdy, then withdraw it after the edge
   task automatic accept(input logic [1:0] vld, input logic [1:0] mode, input logic [1:0] nk,
                         input logic [7:0] f0, input logic [7:0] f1, input logic [1:0] exp_rdy,
                         input string nm);
      req_vld = vld; req_mode = mode; req_newkey = nk; fr0 = f0; fr1 = f1;
      #1;
      chk({nm, " rdy"}, req_rdy, exp_rdy);
      step();
      req_vld = 2'b00;
   endtask

   // called in the START cycle: enter RUN, deliver n frames, expect done
   task automatic finish_run(input int n, input logic id, input string nm);
      step();
      frame_done = 1'b1;
      repeat (n) step();
      frame_done = 1'b0;
      chk({nm, " done"}, done, 1'b1);
      chk({nm, " done_id"}, done_id, id);
      step();
      chk({nm, " idle"}, {busy, done}, 2'b00);
   endtask

   vec_t vt[7];

   initial begin
      int cnt;
      int ng;
      int last_c;
      logic [1:0] exp_g;

      // vld  mode   nk     f0  f1  rdy    kt hs as er code id nfr
      vt[0] = '{2'b01, 2'b00, 2'b00, 8'd0, 8'd5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 0};
      vt[1] = '{2'b10, 2'b10, 2'b00, 8'd1, 8'd2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 0};
      vt[2] = '{2'b11, 2'b00, 2'b00, 8'd1, 8'd1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1};
      vt[3] = '{2'b11, 2'b11, 2'b10, 8'd1, 8'd1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1};
      vt[4] = '{2'b11, 2'b01, 2'b00, 8'd2, 8'd1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2};
      vt[5] = '{2'b01, 2'b00, 2'b01, 8'd1, 8'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1};
      vt[6] = '{2'b10, 2'b10, 2'b00, 8'd0, 8'd3, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3};

      repeat (3) step();
      chk("reset outs", {busy, done, err, err_code, key_trigger, hash_start, aead_start, grant_id, done_id},
          10'd0);
      rst = 1'b0;
      step();
      chk("idle rdy", req_rdy, 2'b00);

      foreach (vt[i]) begin
         accept(vt[i].vld, vt[i].mode, vt[i].nk, vt[i].f0, vt[i].f1, vt[i].rdy, $sformatf("v%0d", i));
         chk($sformatf("v%0d first", i),
             {busy, grant_id, key_trigger, hash_start, aead_start, err, err_code},
             {1'b1, vt[i].id, vt[i].kt, vt[i].hs & ~vt[i].kt & ~vt[i].er,
              vt[i].as_ & ~vt[i].kt & ~vt[i].er, vt[i].er, vt[i].code});
         if (vt[i].er) begin
            chk($sformatf("v%0d err_id", i), done_id, vt[i].id);
            step();
            chk($sformatf("v%0d err clr", i), {busy, err}, 2'b00);
         end else begin
            if (vt[i].kt) begin
               key_done = 1'b1;
               step();
               key_done = 1'b0;
               chk($sformatf("v%0d start", i), {key_trigger, hash_start, aead_start},
                   {1'b0, vt[i].hs, vt[i].as_});
            end
            finish_run(vt[i].nfr, vt[i].id, $sformatf("v%0d", i));
         end
      end

      // AEAD with a fresh key, key_done arriving late
      accept(2'b10, 2'b10, 2'b10, 8'd0, 8'd2, 2'b10, "A");
      chk("A trig", key_trigger, 1'b1);
      step();
      chk("A trig once", {key_trigger, aead_start, busy}, 3'b001);
      repeat (3) step();
      key_done = 1'b1;
      step();
      key_done = 1'b0;
      chk("A start", {aead_start, hash_start}, 2'b10);
      finish_run(2, 1'b1, "A");
      accept(2'b10, 2'b10, 2'b00, 8'd0, 8'd1, 2'b10, "A2");
      chk("A2 keyless start", {key_trigger, aead_start, err}, 3'b010);
      finish_run(1, 1'b1, "A2");

      // watchdog in RUN clears key validity
      accept(2'b01, 2'b00, 2'b00, 8'd2, 8'd0, 2'b01, "T");
      chk("T start", hash_start, 1'b1);
      step();
      cnt = 0;
      while (!err && cnt < 200) begin
         step();
         cnt++;
      end
      chk("T cycles", cnt, 1 << TW);
      chk("T code", {err, err_code, done_id, done}, 5'b1_11_0_0);
      step();
      accept(2'b10, 2'b10, 2'b00, 8'd0, 8'd1, 2'b10, "T2");
      chk("T2 nokey", {err, err_code, aead_start}, 4'b1_10_0);
      step();

      // reset in the middle of a keyed job
      accept(2'b01, 2'b01, 2'b01, 8'd3, 8'd0, 2'b01, "R");
      key_done = 1'b1;
      step();
      key_done = 1'b0;
      step();
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("R abort", {busy, done, err}, 3'b000);
      step();
      chk("R quiet", {busy, done, err}, 3'b000);

      // both requesters hold valid: alternate from requester 0, 4-cycle turnaround
      req_vld = 2'b11; req_mode = 2'b00; req_newkey = 2'b00; fr0 = 8'd1; fr1 = 8'd1;
      frame_done = 1'b1;
      ng = 0; last_c = 0; exp_g = 2'b01;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         #1;
         if (req_rdy != 2'b00) begin
            chk($sformatf("B grant%0d", ng), req_rdy, exp_g);
            if (ng > 0) chk($sformatf("B gap%0d", ng), c - last_c, 4);
            exp_g = ~exp_g;
            last_c = c;
            ng++;
         end
         step();
      end
      req_vld = 2'b00;
      chk("B count", ng, 4);
      repeat (5) step();
      frame_done = 1'b0;
      chk("B idle", busy, 1'b0);

      accept(2'b01, 2'b01, 2'b00, 8'd1, 8'd0, 2'b01, "R2");
      chk("R2 key lost", {err, err_code, done_id}, 4'b1_10_0);
      step();

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout: passed %0d of %0d", pass_cnt, tot_cnt);
      $fatal(1);
   end

endmodule
